// File: rtl/row_pack_if.sv
// Sample-in / row-out bundle for row_pack.
// master: the side that produces samples and consumes rows.
// slave: row_pack itself.
interface row_pack_if #(
  parameter int QW = 12
);
  logic [QW-1:0]       s_data;
  logic                s_valid;
  logic                s_hold;
  logic [7:0][QW-1:0]  q;        // q[i] is column i, each element two's complement
  logic [2:0]          q_cnt;
  logic                q_valid;
  logic                q_hold;

  modport master (
    output s_data, s_valid, q_hold,
    input  s_hold, q, q_cnt, q_valid
  );

  modport slave (
    input  s_data, s_valid, q_hold,
    output s_hold, q, q_cnt, q_valid
  );
endinterface

// File: rtl/row_pack.sv
// Purpose: packs a row-major serial stream of 8x8 blocks into 8-wide rows using ping-pong row buffers.
// Latency: q_valid one cycle after column 7 of a row is accepted; q driven straight from buffer registers.
// Backpressure: s_hold rises only when both buffers hold complete rows, from registered state only.
// Option: define ROW_PACK_LEVEL_SHIFT_EN to store s_data[7:0]-128 (pixel level shift) instead of s_data.
module row_pack #(
  parameter int QW = 12
) (
  input  logic clk,
  input  logic reset,
  row_pack_if.slave io
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_CMPL  = 2'd2;

  // Buffer bookkeeping: per-buffer state and row tag, plus fill/output pointers.
  logic [1:0][1:0] st_q, st_d;
  logic [1:0][2:0] tag_q, tag_d;
  logic [2:0]      fill_col_q, fill_col_d;
  logic [2:0]      in_row_q, in_row_d;
  logic [2:0]      out_row_q, out_row_d;
  logic            fill_sel_q, fill_sel_d;
  logic            out_sel_q, out_sel_d;

  // Row data, deliberately without reset.
  logic [7:0][QW-1:0] row_q [2];
  logic [7:0][QW-1:0] row_d [2];

  logic [QW-1:0] sample;
  logic          hold;
  logic          out_vld;
  logic          accept;
  logic          xfer;

`ifdef ROW_PACK_LEVEL_SHIFT_EN
  logic [8:0] shifted;
  // Unsigned pixel recentred around zero; upper input bits are ignored.
  assign shifted = {1'b0, io.s_data[7:0]} - 9'd128;
  assign sample  = {{(QW-9){shifted[8]}}, shifted};
`else
  assign sample  = io.s_data;
`endif

  // Hold depends only on registered state, so there is no s_valid -> s_hold path.
  assign hold    = (st_q[0] == ST_CMPL) && (st_q[1] == ST_CMPL);
  assign out_vld = (st_q[out_sel_q] == ST_CMPL);
  assign accept  = io.s_valid && !hold;
  assign xfer    = out_vld && !io.q_hold;

  assign io.s_hold  = hold;
  assign io.q_valid = out_vld;
  assign io.q       = row_q[out_sel_q];
  // Tag and output row counter agree because rows leave in acceptance order;
  // the counter covers the idle case where no buffer is complete.
  assign io.q_cnt   = out_vld ? tag_q[out_sel_q] : out_row_q;

  // Next-state: row transfer frees the output buffer, sample acceptance fills the other one.
  // The two never touch the same buffer: the fill buffer is never COMPLETE while hold is low.
  always_comb begin
    st_d       = st_q;
    tag_d      = tag_q;
    fill_col_d = fill_col_q;
    in_row_d   = in_row_q;
    out_row_d  = out_row_q;
    fill_sel_d = fill_sel_q;
    out_sel_d  = out_sel_q;
    row_d      = row_q;

    if (xfer) begin
      st_d[out_sel_q] = ST_EMPTY;
      out_sel_d       = !out_sel_q;
      out_row_d       = out_row_q + 3'd1;
    end

    if (accept) begin
      row_d[fill_sel_q][fill_col_q] = sample;
      st_d[fill_sel_q]              = ST_FILL;
      fill_col_d                    = fill_col_q + 3'd1;
      if (fill_col_q == 3'd7) begin
        st_d[fill_sel_q]  = ST_CMPL;
        tag_d[fill_sel_q] = in_row_q;
        in_row_d          = in_row_q + 3'd1;
        fill_sel_d        = !fill_sel_q;
      end
    end
  end

  // Control state with asynchronous clear; discards any partial or complete rows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q       <= '0;
      tag_q      <= '0;
      fill_col_q <= '0;
      in_row_q   <= '0;
      out_row_q  <= '0;
      fill_sel_q <= 1'b0;
      out_sel_q  <= 1'b0;
    end else begin
      st_q       <= st_d;
      tag_q      <= tag_d;
      fill_col_q <= fill_col_d;
      in_row_q   <= in_row_d;
      out_row_q  <= out_row_d;
      fill_sel_q <= fill_sel_d;
      out_sel_q  <= out_sel_d;
    end
  end

  // Row data registers; content is meaningless until its buffer is COMPLETE.
  always_ff @(posedge clk) begin
    row_q <= row_d;
  end

endmodule

// File: tb/tb_row_pack.sv
// Directed bench for row_pack: streaming, backpressure, random handshakes, mid-block reset, storage format.
module tb_row_pack;
  localparam int QW = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  row_pack_if #(.QW(QW)) bus ();

  row_pack #(.QW(QW)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0][QW-1:0] mk_row(input int base);
    logic [7:0][QW-1:0] r;
    for (int i = 0; i < 8; i++) r[i] = QW'(base + i);
    return r;
  endfunction

  task automatic do_reset();
    bus.s_valid = 1'b0;
    bus.q_hold  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.q_hold  = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (bus.q_valid !== 1'b0) begin failures++; $display("FAIL reset_q_valid got=%b want=0", bus.q_valid); end
    checks++; if (bus.s_hold !== 1'b0) begin failures++; $display("FAIL reset_s_hold got=%b want=0", bus.s_hold); end
    checks++; if (bus.q_cnt !== 3'd0) begin failures++; $display("FAIL reset_q_cnt got=%0d want=0", bus.q_cnt); end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.q_valid !== 1'b0) begin failures++; $display("FAIL idle_q_valid got=%b want=0", bus.q_valid); end
    checks++; if (bus.s_hold !== 1'b0) begin failures++; $display("FAIL idle_s_hold got=%b want=0", bus.s_hold); end
  endtask

  task automatic test_stream();
    int r;
    do_reset();
    bus.q_hold = 1'b0;
    for (int k = 0; k <= 64; k++) begin
      checks++;
      if (bus.q_valid !== (k > 0 && k % 8 == 0)) begin
        failures++; $display("FAIL stream_q_valid k=%0d got=%b want=%b", k, bus.q_valid, (k > 0 && k % 8 == 0));
      end
      if (k > 0 && k % 8 == 0) begin
        r = k / 8 - 1;
        checks++; if (bus.q_cnt !== 3'(r)) begin failures++; $display("FAIL stream_q_cnt row=%0d got=%0d want=%0d", r, bus.q_cnt, r); end
        checks++; if (bus.q !== mk_row(8 * r)) begin failures++; $display("FAIL stream_row row=%0d got=%h want=%h", r, bus.q, mk_row(8 * r)); end
      end
      checks++; if (bus.s_hold !== 1'b0) begin failures++; $display("FAIL stream_s_hold k=%0d got=%b want=0", k, bus.s_hold); end
      if (k < 64) begin
        bus.s_valid = 1'b1;
        bus.s_data  = QW'(k);
      end else begin
        bus.s_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold();
    int sent;
    int exp_r;
    do_reset();
    bus.q_hold = 1'b1;
    sent = 0;
    for (int c = 0; c < 24; c++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = QW'(300 + sent);
      checks++; if (bus.s_hold !== (sent >= 16)) begin failures++; $display("FAIL hold_s_hold sent=%0d got=%b want=%b", sent, bus.s_hold, (sent >= 16)); end
      checks++; if (bus.q_valid !== (sent >= 8)) begin failures++; $display("FAIL hold_q_valid sent=%0d got=%b want=%b", sent, bus.q_valid, (sent >= 8)); end
      if (sent >= 8) begin
        checks++; if (bus.q_cnt !== 3'd0) begin failures++; $display("FAIL hold_q_cnt got=%0d want=0", bus.q_cnt); end
        checks++; if (bus.q !== mk_row(300)) begin failures++; $display("FAIL hold_row0_stable got=%h want=%h", bus.q, mk_row(300)); end
      end
      if (!bus.s_hold) sent++;
      @(posedge clk); #1;
    end
    bus.q_hold = 1'b0;
    exp_r = 0;
    for (int j = 0; j < 16; j++) begin
      bus.s_valid = (sent < 24);
      bus.s_data  = QW'(300 + sent);
      if (j == 0) begin
        checks++; if (bus.s_hold !== 1'b1) begin failures++; $display("FAIL release_s_hold_same got=%b want=1", bus.s_hold); end
      end
      if (j == 1) begin
        checks++; if (bus.s_hold !== 1'b0) begin failures++; $display("FAIL release_s_hold_next got=%b want=0", bus.s_hold); end
      end
      if (bus.q_valid) begin
        checks++; if (bus.q_cnt !== 3'(exp_r)) begin failures++; $display("FAIL release_q_cnt got=%0d want=%0d", bus.q_cnt, exp_r); end
        checks++; if (bus.q !== mk_row(300 + 8 * exp_r)) begin failures++; $display("FAIL release_row r=%0d got=%h want=%h", exp_r, bus.q, mk_row(300 + 8 * exp_r)); end
        exp_r++;
      end
      if (bus.s_valid && !bus.s_hold) sent++;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    checks++; if (exp_r !== 3) begin failures++; $display("FAIL release_rows got=%0d want=3", exp_r); end
    checks++; if (sent !== 24) begin failures++; $display("FAIL release_samples got=%0d want=24", sent); end
  endtask

  task automatic test_random();
    int sent;
    int rows;
    int cyc;
    logic [QW-1:0] sb[$];
    logic [7:0][QW-1:0] exp_q;
    logic [7:0][QW-1:0] last_q;
    logic [2:0] last_cnt;
    logic was_held;
    do_reset();
    sent = 0; rows = 0; cyc = 0; was_held = 1'b0;
    last_q = '0; last_cnt = '0;
    while (rows < 80 && cyc < 6000) begin
      bus.s_valid = (sent < 640) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.s_data  = QW'($urandom_range(0, 4095));
      bus.q_hold  = 1'($urandom_range(0, 1));
      if (was_held) begin
        checks++;
        if (bus.q_valid !== 1'b1 || bus.q !== last_q || bus.q_cnt !== last_cnt) begin
          failures++; $display("FAIL rand_stable got=%b/%0d/%h want=1/%0d/%h", bus.q_valid, bus.q_cnt, bus.q, last_cnt, last_q);
        end
      end
      if (bus.s_valid && !bus.s_hold) begin
        sb.push_back(bus.s_data);
        sent++;
      end
      was_held = bus.q_valid && bus.q_hold;
      last_q   = bus.q;
      last_cnt = bus.q_cnt;
      if (bus.q_valid && !bus.q_hold) begin
        checks++;
        if (sb.size() < 8) begin
          failures++; $display("FAIL rand_underflow have=%0d want>=8", sb.size());
        end else begin
          for (int i = 0; i < 8; i++) exp_q[i] = sb.pop_front();
          if (bus.q !== exp_q) begin failures++; $display("FAIL rand_row r=%0d got=%h want=%h", rows, bus.q, exp_q); end
        end
        checks++; if (bus.q_cnt !== 3'(rows % 8)) begin failures++; $display("FAIL rand_q_cnt r=%0d got=%0d want=%0d", rows, bus.q_cnt, rows % 8); end
        rows++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.s_valid = 1'b0;
    bus.q_hold  = 1'b0;
    checks++; if (rows !== 80) begin failures++; $display("FAIL rand_rows got=%0d want=80", rows); end
  endtask

  task automatic test_reset_mid();
    int waited;
    do_reset();
    bus.q_hold = 1'b1;
    for (int k = 0; k < 13; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = QW'(50 + k);
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    checks++; if (bus.q_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_q_valid got=%b want=1", bus.q_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.q_valid !== 1'b0) begin failures++; $display("FAIL mid_async_q_valid got=%b want=0", bus.q_valid); end
    checks++; if (bus.q_cnt !== 3'd0) begin failures++; $display("FAIL mid_async_q_cnt got=%0d want=0", bus.q_cnt); end
    checks++; if (bus.s_hold !== 1'b0) begin failures++; $display("FAIL mid_async_s_hold got=%b want=0", bus.s_hold); end
    @(posedge clk); #1;
    reset = 1'b0;
    bus.q_hold = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = QW'(100 + k);
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    waited = 0;
    while (!bus.q_valid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++; if (waited !== 0) begin failures++; $display("FAIL mid_latency got=%0d want=0 extra cycles", waited); end
    checks++; if (bus.q_cnt !== 3'd0) begin failures++; $display("FAIL mid_q_cnt got=%0d want=0", bus.q_cnt); end
    checks++; if (bus.q !== mk_row(100)) begin failures++; $display("FAIL mid_row got=%h want=%h", bus.q, mk_row(100)); end
    @(posedge clk); #1;
  endtask

  task automatic test_format();
    logic [QW-1:0] vin  [8];
    logic [QW-1:0] vexp [8];
`ifdef ROW_PACK_LEVEL_SHIFT_EN
    vin  = '{12'd0, 12'd128, 12'd255, 12'hF80, 12'd1, 12'd127, 12'd200, 12'hA40};
    vexp = '{-12'sd128, 12'sd0, 12'sd127, 12'sd0, -12'sd127, -12'sd1, 12'sd72, -12'sd64};
`else
    vin  = '{-12'sd5, 12'sd0, 12'sd2047, -12'sd2048, 12'sd1, -12'sd1, 12'sd100, -12'sd100};
    vexp = '{-12'sd5, 12'sd0, 12'sd2047, -12'sd2048, 12'sd1, -12'sd1, 12'sd100, -12'sd100};
`endif
    do_reset();
    bus.q_hold = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = vin[k];
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    checks++; if (bus.q_valid !== 1'b1) begin failures++; $display("FAIL fmt_q_valid got=%b want=1", bus.q_valid); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.q[i] !== vexp[i]) begin
        failures++; $display("FAIL fmt_col%0d got=%0d want=%0d", i, $signed(bus.q[i]), $signed(vexp[i]));
      end
    end
    bus.q_hold = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.q_hold  = 1'b0;
    test_reset();
    test_stream();
    test_hold();
    test_random();
    test_reset_mid();
    test_format();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
